peripheral_mpi_bus_master: RTL

//  Initiator side of the 16-bit MPI peripheral bus (per_addr/per_din/per_dout/per_en/per_we).

---
 rtl/peripheral_mpi_pkg.sv | 48 ++++
 rtl/peripheral_mpi_bus_master.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/peripheral_mpi_pkg.sv
// ---------------------------------------------------------------------------
// peripheral_mpi_pkg
//   Shared types and helpers for the MPI peripheral bus initiator.
//   - mpi_state_e : initiator FSM states
//   - PER_DW      : peripheral data bus width
//   - WE_*        : per_we byte-lane encodings
//   - write_lanes : byte-lane enables for a write command
//   - byte_dup    : replicate a byte onto both lanes of the data bus
//   - read_extract: shape raw per_dout into the host response word
// ---------------------------------------------------------------------------
package peripheral_mpi_pkg;

  localparam int unsigned PER_DW = 16;

  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_LO   = 2'b01;
  localparam logic [1:0] WE_HI   = 2'b10;
  localparam logic [1:0] WE_WORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } mpi_state_e;

  // Word accesses always enable both lanes, even when misaligned.
  function automatic logic [1:0] write_lanes(input logic byte_acc, input logic addr0);
    if (!byte_acc) begin
      return WE_WORD;
    end
    return addr0 ? WE_HI : WE_LO;
  endfunction

  function automatic logic [PER_DW-1:0] byte_dup(input logic [7:0] b);
    return {b, b};
  endfunction

  function automatic logic [PER_DW-1:0] read_extract(input logic              byte_acc,
                                                     input logic              addr0,
                                                     input logic [PER_DW-1:0] dout);
    if (!byte_acc) begin
      return dout;
    end
    return {8'h00, addr0 ? dout[15:8] : dout[7:0]};
  endfunction

endpackage

// File: rtl/peripheral_mpi_bus_master.sv
// ---------------------------------------------------------------------------
// peripheral_mpi_bus_master
//   Initiator on the 16-bit MPI peripheral bus. Takes one read/write command
//   (word or byte) from a host valid/ready port, performs a single-cycle
//   peripheral access, and returns read data or a write acknowledge on a
//   valid/ready response port. One transaction outstanding at a time.
//
// Parameters
//   ADDR_W     byte-address width of cmd_addr; per_addr = cmd_addr[ADDR_W-1:1]
//   READ_WAIT  cycles (0..7) after the access cycle before per_dout is sampled
//
// Ports
//   mclk, puc_rst_n        clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake (ready only while idle)
//   cmd_write, cmd_byte    access type: write/read, byte/word
//   cmd_addr, cmd_wdata    byte address and write data
//   rsp_valid/rsp_ready    response handshake
//   rsp_rdata, rsp_err     read data (0 for writes), misaligned-word flag
//   per_addr, per_din      peripheral word address and write data
//   per_dout               peripheral read data (OR bus)
//   per_en, per_we         access strobe (one cycle) and byte write enables
// ---------------------------------------------------------------------------
module peripheral_mpi_bus_master
  import peripheral_mpi_pkg::*;
#(
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned READ_WAIT = 0
) (
  input  logic              mclk,
  input  logic              puc_rst_n,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic              cmd_byte,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [PER_DW-1:0] cmd_wdata,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [PER_DW-1:0] rsp_rdata,
  output logic              rsp_err,

  output logic [ADDR_W-2:0] per_addr,
  output logic [PER_DW-1:0] per_din,
  input  logic [PER_DW-1:0] per_dout,
  output logic              per_en,
  output logic [1:0]        per_we
);

  // Counter load value: the WAIT state samples when the counter reaches zero,
  // so it starts at READ_WAIT-1.
  localparam logic [2:0] WAIT_LAST = (READ_WAIT == 0) ? 3'd0 : 3'(READ_WAIT - 1);

  mpi_state_e        state_q;

  // Latched command attributes needed after the access cycle.
  logic              cmd_write_q;
  logic              cmd_byte_q;
  logic              cmd_a0_q;

  logic [2:0]        wait_cnt_q;

  // Registered bus and host-facing outputs.
  logic              cmd_ready_q;
  logic              rsp_valid_q;
  logic [PER_DW-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic [ADDR_W-2:0] per_addr_q;
  logic [PER_DW-1:0] per_din_q;
  logic              per_en_q;
  logic [1:0]        per_we_q;

  // Response word as it would be captured from the bus this cycle.
  logic [PER_DW-1:0] rd_data_d;

  assign rd_data_d = read_extract(cmd_byte_q, cmd_a0_q, per_dout);

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state_q     <= IDLE;
      cmd_write_q <= 1'b0;
      cmd_byte_q  <= 1'b0;
      cmd_a0_q    <= 1'b0;
      wait_cnt_q  <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      per_addr_q  <= '0;
      per_din_q   <= '0;
      per_en_q    <= 1'b0;
      per_we_q    <= WE_NONE;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            state_q     <= ACCESS;
            cmd_ready_q <= 1'b0;
            cmd_write_q <= cmd_write;
            cmd_byte_q  <= cmd_byte;
            cmd_a0_q    <= cmd_addr[0];
            // Bus outputs are loaded here so they are valid throughout ACCESS.
            // Dropping address bit 0 also realigns misaligned word accesses.
            per_en_q    <= 1'b1;
            per_addr_q  <= cmd_addr[ADDR_W-1:1];
            if (cmd_write) begin
              per_we_q  <= write_lanes(cmd_byte, cmd_addr[0]);
              per_din_q <= cmd_byte ? byte_dup(cmd_wdata[7:0]) : cmd_wdata;
            end else begin
              per_we_q  <= WE_NONE;
              per_din_q <= '0;
            end
          end
        end

        ACCESS: begin
          per_en_q  <= 1'b0;
          per_we_q  <= WE_NONE;
          per_din_q <= '0;
          rsp_err_q <= !cmd_byte_q && cmd_a0_q;
          if (cmd_write_q) begin
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (READ_WAIT == 0) begin
            rsp_rdata_q <= rd_data_d;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            wait_cnt_q  <= WAIT_LAST;
            state_q     <= WAIT;
          end
        end

        WAIT: begin
          if (wait_cnt_q == '0) begin
            rsp_rdata_q <= rd_data_d;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            wait_cnt_q  <= wait_cnt_q - 3'd1;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign per_addr  = per_addr_q;
  assign per_din   = per_din_q;
  assign per_en    = per_en_q;
  assign per_we    = per_we_q;

endmodule
